// File: rtl/banco_pkg.sv
// Shared types and default sizes for the two-write/two-read register file.
package banco_pkg;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 3;

endpackage

// File: rtl/banco_clr_seq.sv
// Clear sequencer: sweeps every entry to zero, automatically after reset and on request.
module banco_clr_seq
  import banco_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clr_done <= done_nxt;
    end
  end

  // cnt wraps to zero naturally on the last entry, ready for the next sweep
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) state_nxt = CLEAR;
      end
      CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (&cnt) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/banco_registros_2w2r.sv
// Register file with two write ports, two registered read ports, forwarding, hold and clear sweep.
module banco_registros_2w2r
  import banco_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int FWD    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] IN1,
  input  logic [DATA_W-1:0] IN2,
  input  logic              WR1,
  input  logic              WR2,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              hold_ctrl,
  input  logic              clr_req,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              busy,
  output logic              clr_done,
  output logic              wr_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic                         clr_we;
  logic [ADDR_W-1:0]            clr_addr;
  logic [DATA_W-1:0]            rd_nxt1, rd_nxt2;

  banco_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Port 1 is assigned last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (WR2) mem[addr2] <= IN2;
      if (WR1) mem[addr1] <= IN1;
    end
  end

  always_comb begin
    rd_nxt1 = mem[rd_addr1];
    if (busy)                                        rd_nxt1 = '0;
    else if ((FWD != 0) && WR1 && (addr1 == rd_addr1)) rd_nxt1 = IN1;
    else if ((FWD != 0) && WR2 && (addr2 == rd_addr1)) rd_nxt1 = IN2;
  end

  always_comb begin
    rd_nxt2 = mem[rd_addr2];
    if (busy)                                        rd_nxt2 = '0;
    else if ((FWD != 0) && WR1 && (addr1 == rd_addr2)) rd_nxt2 = IN1;
    else if ((FWD != 0) && WR2 && (addr2 == rd_addr2)) rd_nxt2 = IN2;
  end

  // Output stage: registered read data and dropped-write flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OUT1   <= '0;
      OUT2   <= '0;
      wr_err <= 1'b0;
    end else begin
      if (!hold_ctrl) begin
        OUT1 <= rd_nxt1;
        OUT2 <= rd_nxt2;
      end
      wr_err <= busy & (WR1 | WR2);
    end
  end

endmodule

// File: tb/tb_banco_registros_2w2r.sv
// Bench for banco_registros_2w2r: directed scenarios plus random traffic against a reference model.
module tb_banco_registros_2w2r;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in1 = '0, in2 = '0;
  logic        wr1 = 1'b0, wr2 = 1'b0;
  logic [2:0]  a1 = '0, a2 = '0, ra1 = '0, ra2 = '0;
  logic        hold = 1'b0, clr_req = 1'b0;

  logic [31:0] f_out1, f_out2, n_out1, n_out2;
  logic        f_busy, f_done, f_err, n_busy, n_done, n_err;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] mem_m [8];
  logic [31:0] o1f, o2f, o1n, o2n;
  int          left;
  logic        done_m, err_m;

  always #5 clk = ~clk;

  banco_registros_2w2r #(.DATA_W(32), .ADDR_W(3), .FWD(1)) u_fwd (
    .clk(clk), .rst(rst), .IN1(in1), .IN2(in2), .WR1(wr1), .WR2(wr2),
    .addr1(a1), .addr2(a2), .rd_addr1(ra1), .rd_addr2(ra2),
    .hold_ctrl(hold), .clr_req(clr_req), .OUT1(f_out1), .OUT2(f_out2),
    .busy(f_busy), .clr_done(f_done), .wr_err(f_err)
  );

  banco_registros_2w2r #(.DATA_W(32), .ADDR_W(3), .FWD(0)) u_nofwd (
    .clk(clk), .rst(rst), .IN1(in1), .IN2(in2), .WR1(wr1), .WR2(wr2),
    .addr1(a1), .addr2(a2), .rd_addr1(ra1), .rd_addr2(ra2),
    .hold_ctrl(hold), .clr_req(clr_req), .OUT1(n_out1), .OUT2(n_out2),
    .busy(n_busy), .clr_done(n_done), .wr_err(n_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_model(input bit fwd, input logic [2:0] ra);
    if (fwd && wr1 && a1 == ra) return in1;
    if (fwd && wr2 && a2 == ra) return in2;
    return mem_m[ra];
  endfunction

  task automatic check_all();
    chk("f_out1", f_out1, o1f);
    chk("f_out2", f_out2, o2f);
    chk("n_out1", n_out1, o1n);
    chk("n_out2", n_out2, o2n);
    chk("f_busy", f_busy, left > 0);
    chk("n_busy", n_busy, left > 0);
    chk("f_done", f_done, done_m);
    chk("n_done", n_done, done_m);
    chk("f_err", f_err, err_m);
    chk("n_err", n_err, err_m);
  endtask

  // One clock: advance the model with the current inputs, then compare after the edge
  task automatic step();
    bit bz;
    bz = (left > 0);
    if (!hold) begin
      o1f = bz ? 32'h0 : rd_model(1'b1, ra1);
      o2f = bz ? 32'h0 : rd_model(1'b1, ra2);
      o1n = bz ? 32'h0 : rd_model(1'b0, ra1);
      o2n = bz ? 32'h0 : rd_model(1'b0, ra2);
    end
    err_m = bz && (wr1 || wr2);
    if (bz) begin
      mem_m[8 - left] = 32'h0;
      left--;
      done_m = (left == 0);
    end else begin
      if (wr2) mem_m[a2] = in2;
      if (wr1) mem_m[a1] = in1;
      done_m = 1'b0;
      if (clr_req) left = 8;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    wr1 = 1'b0; wr2 = 1'b0; hold = 1'b0; clr_req = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    o1f = '0; o2f = '0; o1n = '0; o2n = '0;
    left = 8; done_m = 1'b0; err_m = 1'b0;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic count_sweep(input string tag);
    int bcnt, dcnt;
    bcnt = 0; dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (f_busy) bcnt++;
      if (f_done) dcnt++;
      step();
    end
    if (f_done) dcnt++;
    chk({tag, "_busy_cycles"}, bcnt, 8);
    chk({tag, "_done_pulses"}, dcnt, 1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem_m[i] = '0;
    idle_in();
    @(posedge clk); #1;
    apply_reset();

    // 1: automatic sweep after reset, then all entries read zero
    count_sweep("rst_sweep");
    for (int a = 0; a < 8; a++) begin
      ra1 = 3'(a); ra2 = 3'(7 - a);
      step();
      chk("clr_rd1", f_out1, 32'h0);
      chk("clr_rd2", n_out2, 32'h0);
    end

    // 2: two independent writes in one cycle
    wr1 = 1; in1 = 32'hA5A5_0001; a1 = 3;
    wr2 = 1; in2 = 32'h0000_BEEF; a2 = 5;
    step();
    idle_in(); ra1 = 3; ra2 = 5;
    step();
    chk("dual_wr_3", n_out1, 32'hA5A5_0001);
    chk("dual_wr_5", n_out2, 32'h0000_BEEF);

    // 3: collision on the same address, port 1 wins
    wr1 = 1; in1 = 32'h1111_1111; a1 = 6;
    wr2 = 1; in2 = 32'h2222_2222; a2 = 6;
    ra1 = 6;
    step();
    chk("coll_fwd", f_out1, 32'h1111_1111);
    idle_in();
    step();
    chk("coll_mem", n_out1, 32'h1111_1111);

    // 4: read-during-write with and without forwarding
    wr1 = 1; in1 = 32'h0000_0022; a1 = 2;
    step();
    wr1 = 1; in1 = 32'hCAFE_0000; a1 = 2; ra1 = 2;
    step();
    chk("fwd1_new", f_out1, 32'hCAFE_0000);
    chk("fwd0_old", n_out1, 32'h0000_0022);
    idle_in();

    // 5: output hold
    wr1 = 1; in1 = 32'd5; a1 = 1;
    step();
    idle_in(); ra1 = 1;
    step();
    chk("hold_pre", f_out1, 32'd5);
    hold = 1; wr1 = 1; in1 = 32'd9; a1 = 1;
    step();
    wr1 = 0;
    step();
    chk("hold_keep", f_out1, 32'd5);
    hold = 0;
    step();
    chk("hold_rel", f_out1, 32'd9);

    // 6: dropped write during sweep, then reset mid-sweep
    wr1 = 1; in1 = 32'h7777_7777; a1 = 4;
    step();
    idle_in();
    clr_req = 1;
    step();
    clr_req = 0;
    step(); step();
    wr1 = 1; in1 = 32'hDEAD_DEAD; a1 = 0;
    step();
    chk("wr_err_pulse", f_err, 1'b1);
    wr1 = 0;
    clr_req = 1;
    step();
    chk("wr_err_clear", f_err, 1'b0);
    clr_req = 0;
    #3;
    apply_reset();
    count_sweep("abort_sweep");
    ra1 = 0; ra2 = 4;
    step();
    chk("lost_write", f_out1, 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      wr1 = ($urandom_range(0, 99) < 50);
      wr2 = ($urandom_range(0, 99) < 50);
      in1 = $urandom; in2 = $urandom;
      a1 = 3'($urandom); a2 = 3'($urandom);
      ra1 = 3'($urandom); ra2 = 3'($urandom);
      hold = ($urandom_range(0, 99) < 10);
      clr_req = ($urandom_range(0, 99) < 3);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
